// File: rtl/bmp_frame_writer.sv
// BMP frame writeback: copies the header/palette from source ROM to destination RAM, then captures the filter pixel stream.
// Optional FRAME_CHECKSUM_EN adds a 16-bit running sum of written pixel bytes.
module bmp_frame_writer #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int HEADER_LEN = 1078,
  parameter int IMG_W      = 100,
  parameter int IMG_H      = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [BIT_WIDTH-1:0]  src_data,
  output logic                  dst_we,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [BIT_WIDTH-1:0]  dst_data,
  output logic                  header_done,
  input  logic                  pix_valid,
  input  logic [BIT_WIDTH-1:0]  pix_data,
  output logic                  frame_done,
  output logic                  busy
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] HDR_LEN_A = ADDR_WIDTH'(HEADER_LEN);
  localparam logic [ADDR_WIDTH-1:0] HDR_LAST  = ADDR_WIDTH'(HEADER_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_TOTAL = ADDR_WIDTH'(IMG_W * IMG_H);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST  = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR_COPY,
    S_PIX,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_hdr_cnt;
  logic [ADDR_WIDTH-1:0] r_pix_cnt;
  logic [ADDR_WIDTH-1:0] r_src_addr;
  logic                  r_dst_we;
  logic [ADDR_WIDTH-1:0] r_dst_addr;
  logic [BIT_WIDTH-1:0]  r_dst_data;
  logic                  r_header_done;
  logic                  r_frame_done;
  logic                  r_busy;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0]           r_checksum;
`endif

  logic w_hdr_wr;
  logic w_pix_acc;
  logic w_pix_last;

  // r_hdr_cnt tracks the HDR_COPY cycle index; the ROM byte for address n lands in cycle n+1.
  assign w_hdr_wr   = (r_hdr_cnt != '0);
  assign w_pix_acc  = pix_valid && (r_pix_cnt < PIX_TOTAL);
  assign w_pix_last = (r_pix_cnt == PIX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hdr_cnt     <= '0;
      r_pix_cnt     <= '0;
      r_src_addr    <= '0;
      r_dst_we      <= 1'b0;
      r_dst_addr    <= '0;
      r_dst_data    <= '0;
      r_header_done <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_checksum    <= '0;
`endif
    end else if ((r_state != S_IDLE) && !start) begin
      // Abort takes priority so a write sampled on this edge is never issued.
      r_state       <= S_IDLE;
      r_hdr_cnt     <= '0;
      r_pix_cnt     <= '0;
      r_src_addr    <= '0;
      r_dst_we      <= 1'b0;
      r_dst_addr    <= '0;
      r_dst_data    <= '0;
      r_header_done <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_checksum    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dst_we <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
          r_checksum <= '0;
`endif
          if (start) begin
            r_state    <= S_HDR_COPY;
            r_busy     <= 1'b1;
            r_hdr_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_src_addr <= '0;
          end
        end

        S_HDR_COPY: begin
          r_dst_we <= w_hdr_wr;
          if (w_hdr_wr) begin
            r_dst_addr <= r_hdr_cnt - ONE;
            r_dst_data <= src_data;
          end
          if (r_hdr_cnt == HDR_LEN_A) begin
            r_state       <= S_PIX;
            r_header_done <= 1'b1;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + ONE;
            if (r_hdr_cnt != HDR_LAST) begin
              r_src_addr <= r_hdr_cnt + ONE;
            end
          end
        end

        S_PIX: begin
          r_dst_we <= w_pix_acc;
          if (w_pix_acc) begin
            r_dst_addr <= HDR_LEN_A + r_pix_cnt;
            r_dst_data <= pix_data;
            r_pix_cnt  <= r_pix_cnt + ONE;
`ifdef FRAME_CHECKSUM_EN
            r_checksum <= r_checksum + 16'(pix_data);
`endif
            if (w_pix_last) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Upstream holds its valid high after the last pixel; those beats are dropped.
          r_dst_we <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_dst_we <= 1'b0;
        end
      endcase
    end
  end

  assign src_addr    = r_src_addr;
  assign dst_we      = r_dst_we;
  assign dst_addr    = r_dst_addr;
  assign dst_data    = r_dst_data;
  assign header_done = r_header_done;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
`ifdef FRAME_CHECKSUM_EN
  assign checksum    = r_checksum;
`endif

endmodule

// File: tb/tb_bmp_frame_writer.sv
// Directed self-checking bench for bmp_frame_writer (default parameters, 1078-byte header, 100x100 image).
module tb_bmp_frame_writer;

  localparam int HL = 1078;
  localparam int NP = 10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] src_addr;
  logic [7:0]  src_data = 8'h00;
  logic        dst_we;
  logic [13:0] dst_addr;
  logic [7:0]  dst_data;
  logic        header_done;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        frame_done;
  logic        busy;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wa[$];
  int wd[$];
  int wc[$];

  bmp_frame_writer #(
    .BIT_WIDTH (8),
    .ADDR_WIDTH(14),
    .HEADER_LEN(HL),
    .IMG_W     (100),
    .IMG_H     (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .dst_we     (dst_we),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .header_done(header_done),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef FRAME_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source ROM: byte k holds k[7:0], one cycle read latency.
  always @(posedge clk) src_data <= src_addr[7:0];

  // Write log sampled mid-cycle.
  always @(negedge clk) begin
    if (dst_we === 1'b1) begin
      wa.push_back(int'(dst_addr));
      wd.push_back(int'(dst_data));
      wc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  // Raises start and returns once header_done is seen (lat = cycles from start edge, -1 on timeout).
  task automatic start_frame(output int lat);
    int se;
    int rise;
    clear_log();
    @(posedge clk); #1;
    start = 1'b1;
    se = cyc + 1;
    rise = -1;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (header_done === 1'b1) begin
        rise = cyc;
        break;
      end
    end
    lat = (rise < 0) ? -1 : rise - se;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (src_addr !== 14'd0) begin n_err++; $display("FAIL rst_src_addr got=%0d exp=0", src_addr); end
    n_cmp++; if (dst_we !== 1'b0) begin n_err++; $display("FAIL rst_dst_we got=%b exp=0", dst_we); end
    n_cmp++; if ({dst_addr, dst_data} !== 22'd0) begin n_err++; $display("FAIL rst_dst got=%h/%h exp=0/0", dst_addr, dst_data); end
    n_cmp++; if ({header_done, frame_done} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {header_done, frame_done}); end
`ifdef FRAME_CHECKSUM_EN
    n_cmp++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL rst_checksum got=%h exp=0000", checksum); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_header();
    int lat;
    int bad;
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    start_frame(lat);
    pix_valid = 1'b0;
    n_cmp++; if (lat !== 1079) begin n_err++; $display("FAIL hdr_latency got=%0d exp=1079", lat); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hdr_busy got=%b exp=1", busy); end
    n_cmp++; if (src_addr !== 14'd1077) begin n_err++; $display("FAIL hdr_src_hold got=%0d exp=1077", src_addr); end
    @(negedge clk); #1;
    n_cmp++; if (wa.size() !== HL) begin n_err++; $display("FAIL hdr_write_count got=%0d exp=%0d", wa.size(), HL); end
    bad = 0;
    for (int k = 0; k < wa.size(); k++) begin
      if (wa[k] != k || wd[k] != (k & 255)) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hdr_content bad_entries got=%0d exp=0", bad); end
    n_cmp++; if (wd.size() > 0 && wd[wd.size()-1] !== 32'h35) begin n_err++; $display("FAIL hdr_last_byte got=%h exp=35", wd[wd.size()-1]); end
  endtask

  task automatic test_pixel_stream();
    int p0;
    int fd_cyc;
    int bad;
    int maxa;
    clear_log();
    @(posedge clk); #1;
    p0 = cyc;
    fd_cyc = -1;
    for (int k = 0; k < NP; k++) begin
      n_cmp++; if (k == NP - 1 && frame_done !== 1'b0) begin n_err++; $display("FAIL pix_early_done got=%b exp=0", frame_done); end
      pix_valid = 1'b1;
      pix_data  = 8'(k);
      @(posedge clk); #1;
      if (frame_done === 1'b1 && fd_cyc < 0) fd_cyc = cyc;
    end
    @(negedge clk); #1;
    n_cmp++; if (fd_cyc - p0 !== NP) begin n_err++; $display("FAIL pix_done_latency got=%0d exp=%0d", fd_cyc - p0, NP); end
    n_cmp++; if (wa.size() !== NP) begin n_err++; $display("FAIL pix_write_count got=%0d exp=%0d", wa.size(), NP); end
    bad = 0;
    maxa = 0;
    for (int j = 0; j < wa.size(); j++) begin
      if (wa[j] != HL + j || wd[j] != (j & 255)) bad++;
      if (wa[j] > maxa) maxa = wa[j];
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pix_content bad_entries got=%0d exp=0", bad); end
    n_cmp++; if (maxa !== HL + NP - 1) begin n_err++; $display("FAIL pix_max_addr got=%0d exp=%0d", maxa, HL + NP - 1); end
    n_cmp++; if (wc.size() > 0 && wc[wc.size()-1] !== fd_cyc) begin n_err++; $display("FAIL pix_last_write_cycle got=%0d exp=%0d", wc[wc.size()-1], fd_cyc); end
  endtask

  task automatic test_overrun();
    int drops;
    clear_log();
    drops = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_data  = 8'h5A;
      if (frame_done !== 1'b1) drops++;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (wa.size() !== 0) begin n_err++; $display("FAIL ovr_writes got=%0d exp=0", wa.size()); end
    n_cmp++; if (drops !== 0) begin n_err++; $display("FAIL ovr_frame_done_drops got=%0d exp=0", drops); end
    n_cmp++; if ({busy, header_done, frame_done, dst_we} !== 4'b1110) begin n_err++; $display("FAIL ovr_flags got=%b exp=1110", {busy, header_done, frame_done, dst_we}); end
  endtask

  task automatic test_abort();
    int lat;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, header_done, frame_done, dst_we} !== 4'b0000) begin n_err++; $display("FAIL abort_done_flags got=%b exp=0000", {busy, header_done, frame_done, dst_we}); end
    start_frame(lat);
    for (int k = 0; k < 4321; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(k);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'(4321);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    n_cmp++; if ({busy, header_done, frame_done, dst_we} !== 4'b0000) begin n_err++; $display("FAIL abort_flags got=%b exp=0000", {busy, header_done, frame_done, dst_we}); end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (wa.size() !== HL + 4321) begin n_err++; $display("FAIL abort_write_count got=%0d exp=%0d", wa.size(), HL + 4321); end
    n_cmp++; if (wa.size() > 0 && wa[wa.size()-1] !== HL + 4320) begin n_err++; $display("FAIL abort_last_addr got=%0d exp=%0d", wa[wa.size()-1], HL + 4320); end
  endtask

  task automatic test_restart_gaps();
    int lat;
    int j;
    int bad;
    int gapbad;
    pix_valid = 1'b0;
    start_frame(lat);
    n_cmp++; if (lat !== 1079) begin n_err++; $display("FAIL gap_restart_latency got=%0d exp=1079", lat); end
    j = 0;
    for (int c = 0; c < 2 * NP + 10; c++) begin
      if (c % 2 == 0) begin
        pix_valid = 1'b1;
        pix_data  = ~8'(j);
        j++;
      end else begin
        pix_valid = 1'b0;
        pix_data  = 8'hEE;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (wa.size() !== HL + NP) begin n_err++; $display("FAIL gap_write_count got=%0d exp=%0d", wa.size(), HL + NP); end
    bad = 0;
    gapbad = 0;
    for (int k = 0; k < wa.size(); k++) begin
      if (k < HL) begin
        if (wa[k] != k || wd[k] != (k & 255)) bad++;
      end else begin
        if (wa[k] != k || wd[k] != (~(k - HL) & 255)) bad++;
        if (k > HL && wc[k] - wc[k-1] != 2) gapbad++;
      end
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL gap_content bad_entries got=%0d exp=0", bad); end
    n_cmp++; if (gapbad !== 0) begin n_err++; $display("FAIL gap_spacing bad_entries got=%0d exp=0", gapbad); end
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL gap_frame_done got=%b exp=1", frame_done); end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    n_cmp++; if ({busy, src_addr != 14'd0} !== 2'b11) begin n_err++; $display("FAIL arst_pre_active got=%b/%0d exp=1/nonzero", busy, src_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", busy); end
    n_cmp++; if (src_addr !== 14'd0) begin n_err++; $display("FAIL arst_src_addr got=%0d exp=0", src_addr); end
    n_cmp++; if ({dst_we, header_done, frame_done} !== 3'b000) begin n_err++; $display("FAIL arst_flags got=%b exp=000", {dst_we, header_done, frame_done}); end
    start = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_post_idle got=%b exp=0", busy); end
  endtask

  task automatic test_checksum();
`ifdef FRAME_CHECKSUM_EN
    int lat;
    n_cmp++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL csum_idle got=%h exp=0000", checksum); end
    pix_valid = 1'b0;
    start_frame(lat);
    for (int k = 0; k < NP; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'hFF;
      @(posedge clk); #1;
    end
    n_cmp++; if ({frame_done, checksum} !== {1'b1, 16'hE8F0}) begin n_err++; $display("FAIL csum_frame got=%b/%h exp=1/e8f0", frame_done, checksum); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (checksum !== 16'hE8F0) begin n_err++; $display("FAIL csum_stable got=%h exp=e8f0", checksum); end
    pix_valid = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL csum_clear got=%h exp=0000", checksum); end
`endif
  endtask

  initial begin
    test_reset();
    test_header();
    test_pixel_stream();
    test_overrun();
    test_abort();
    test_restart_gaps();
    test_async_reset();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
